// File: rtl/ram_req_pkg.sv
// Shared definitions for the ram_access request front-end: op encoding and
// the queued request record layout.
package ram_req_pkg;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   localparam int REQ_W = 65;

   typedef struct packed {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   // The op ram_access is executing; is_real=0 marks a filler read.
   typedef struct packed {
      logic is_real;
      req_t req;
   } op_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count. A push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       ACLK,
   input  logic                       ARESETn,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != FULL_CNT) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge ACLK) begin
      mem_q <= mem_d;
      if (!ARESETn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/ram_request_port.sv
// Queues upstream read/write requests and feeds them to ram_access exactly at
// its ACK cycles, filling idle slots with harmless cached-line reads.
module ram_request_port
   import ram_req_pkg::*;
#(
   parameter int REQ_DEPTH = 4,
   parameter int RSP_DEPTH = 4
) (
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rw,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        wr_done,
   output logic        RW,
   output logic [31:0] ADDRESS,
   output logic [31:0] IN_DATA,
   input  logic [31:0] OUT_DATA,
   input  logic        ACK,
   output logic        busy
);

   localparam logic [$clog2(REQ_DEPTH):0] REQ_FULL = ($clog2(REQ_DEPTH)+1)'(REQ_DEPTH);

   req_t                        req_in, head;
   logic                        req_push, req_pop;
   logic [$clog2(REQ_DEPTH):0]  req_count;
   logic                        rsp_push, rsp_pop;
   logic [$clog2(RSP_DEPTH):0]  rsp_count;

   op_t         cur_q, cur_d, nxt;
   logic [31:0] last_addr_q, last_addr_d;
   logic        wr_done_q, wr_done_d;
   logic        act, head_valid, rd_pending, head_eligible;

   assign req_in = '{rw: req_rw, addr: req_addr, wdata: req_wdata};

   sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .push      (req_push),
      .push_data (req_in),
      .pop       (req_pop),
      .pop_data  (head),
      .count     (req_count)
   );

   sync_fifo #(.WIDTH(32), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .push      (rsp_push),
      .push_data (OUT_DATA),
      .pop       (rsp_pop),
      .pop_data  (rsp_data),
      .count     (rsp_count)
   );

   // A read may only issue if its response slot is guaranteed, counting the
   // read currently executing whose data has not been pushed yet.
   always_comb begin
      act           = ACK && ARESETn;
      head_valid    = (req_count != '0);
      rd_pending    = cur_q.is_real && (cur_q.req.rw == RW_READ);
      head_eligible = head_valid &&
                      ((head.rw == RW_WRITE) ||
                       ((int'(rsp_count) + int'(rd_pending)) < RSP_DEPTH));

      nxt.is_real   = 1'b0;
      nxt.req.rw    = RW_READ;
      nxt.req.addr  = last_addr_q;
      nxt.req.wdata = '0;
      if (head_eligible) begin
         nxt.is_real = 1'b1;
         nxt.req     = head;
      end

      req_pop     = act && head_eligible;
      rsp_push    = act && rd_pending;
      wr_done_d   = act && cur_q.is_real && (cur_q.req.rw == RW_WRITE);
      cur_d       = act ? nxt : cur_q;
      last_addr_d = (act && nxt.is_real) ? nxt.req.addr : last_addr_q;
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         cur_q       <= '0;
         last_addr_q <= '0;
         wr_done_q   <= 1'b0;
      end else begin
         cur_q       <= cur_d;
         last_addr_q <= last_addr_d;
         wr_done_q   <= wr_done_d;
      end
   end

   // ram_access samples the port only on ACK, so the next op is shown just then.
   assign RW        = act ? nxt.req.rw    : cur_q.req.rw;
   assign ADDRESS   = act ? nxt.req.addr  : cur_q.req.addr;
   assign IN_DATA   = act ? nxt.req.wdata : cur_q.req.wdata;

   assign req_ready = ARESETn && ((req_count != REQ_FULL) || req_pop);
   assign req_push  = req_valid && req_ready;
   assign rsp_valid = (rsp_count != '0);
   assign rsp_pop   = rsp_valid && rsp_ready;
   assign wr_done   = wr_done_q;
   assign busy      = head_valid || cur_q.is_real;

endmodule

// File: tb/tb_ram_request_port.sv
// Directed bench for ram_request_port with a small behavioural ram_access
// model (one-line cache, hit ACK every 2 cycles, slow misses).
module tb_ram_request_port;

   localparam int MISS_LAT = 8;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic        req_valid, req_ready, req_rw;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic        wr_done;
   logic        RW;
   logic [31:0] ADDRESS, IN_DATA, OUT_DATA;
   logic        ACK;
   logic        busy;

   int errors = 0;
   int checks = 0;

   ram_request_port #(.REQ_DEPTH(4), .RSP_DEPTH(4)) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rw    (req_rw),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .wr_done   (wr_done),
      .RW        (RW),
      .ADDRESS   (ADDRESS),
      .IN_DATA   (IN_DATA),
      .OUT_DATA  (OUT_DATA),
      .ACK       (ACK),
      .busy      (busy)
   );

   always #5 ACLK = ~ACLK;

   // ram_access model: latches the presented op on ACK or reset exit.
   logic [31:0] mem [int];
   logic        snap_rw;
   logic [31:0] snap_addr, snap_wdata, rdata;
   int          cnt, cached_line, line, wb80_count = 0;
   bit          dirty, exiting;

   always @(negedge ACLK) begin
      snap_rw    = RW;
      snap_addr  = ADDRESS;
      snap_wdata = IN_DATA;
   end

   always @(posedge ACLK) begin
      if (!ARESETn) begin
         cnt         = 0;
         exiting     = 1'b1;
         cached_line = -1;
         dirty       = 1'b0;
         ACK        <= 1'b0;
         OUT_DATA   <= '0;
      end else if (exiting || ACK) begin
         exiting = 1'b0;
         ACK    <= 1'b0;
         line    = int'(snap_addr >> 1);
         if (line != cached_line) begin
            if (dirty && cached_line == 32'h80) wb80_count++;
            cached_line = line;
            dirty       = 1'b0;
            cnt         = MISS_LAT;
         end else begin
            cnt = 1;
         end
         if (snap_rw) begin
            mem[snap_addr] = snap_wdata;
            dirty          = 1'b1;
         end
         rdata = mem.exists(snap_addr) ? mem[snap_addr] : 32'h0;
      end else if (cnt > 0) begin
         cnt--;
         if (cnt == 0) begin
            ACK      <= 1'b1;
            OUT_DATA <= rdata;
         end
      end
   end

   // Response and write-completion collection.
   logic [31:0] got [$];
   int          wd_count = 0;

   always @(negedge ACLK) begin
      if (ARESETn && rsp_valid && rsp_ready) got.push_back(rsp_data);
      if (wr_done) wd_count++;
   end

   function automatic logic [31:0] fetch(input int i);
      return (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
      int waited = 0;
      req_valid = 1'b1;
      req_rw    = rw;
      req_addr  = addr;
      req_wdata = wdata;
      @(negedge ACLK);
      while (!req_ready && waited < 300) begin
         @(negedge ACLK);
         waited++;
      end
      check_output("req_accept", {31'd0, req_ready}, 32'd1);
      @(posedge ACLK);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge ACLK);
         #1;
      end
   endtask

   task automatic wait_responses(input int n);
      int k = 0;
      while (got.size() < n && k < 500) begin
         @(negedge ACLK);
         k++;
      end
   endtask

   int wd_base, wb_base, rsp_before, wd_before;

   initial begin
      mem[32'h100] = 32'h5555;
      mem[32'h101] = 32'h6666;
      ARESETn   = 1'b0;
      req_valid = 1'b0;
      req_rw    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;

      // Reset values
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check_output("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check_output("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_output("rst_wr_done",   {31'd0, wr_done},   32'd0);
      check_output("rst_busy",      {31'd0, busy},      32'd0);
      check_output("rst_rw",        {31'd0, RW},        32'd0);
      check_output("rst_address",   ADDRESS,            32'd0);
      check_output("rst_in_data",   IN_DATA,            32'd0);
      @(posedge ACLK);
      #1;
      ARESETn   = 1'b1;
      rsp_ready = 1'b1;
      @(negedge ACLK);
      check_output("ready_after_rst", {31'd0, req_ready}, 32'd1);
      idle(1);

      // Two reads, no extra responses from filler traffic
      $display("[TB] two reads");
      apply_stimulus(1'b0, 32'h100, 32'h0);
      apply_stimulus(1'b0, 32'h101, 32'h0);
      wait_responses(2);
      idle(20);
      check_output("rd_count", got.size(), 32'd2);
      check_output("rd_0x100", fetch(0), 32'h5555);
      check_output("rd_0x101", fetch(1), 32'h6666);
      got.delete();

      // Write then read back
      $display("[TB] write then read");
      wd_base = wd_count;
      apply_stimulus(1'b1, 32'h100, 32'hDEAD);
      apply_stimulus(1'b0, 32'h100, 32'h0);
      wait_responses(1);
      idle(10);
      check_output("wr_done_once", wd_count - wd_base, 32'd1);
      check_output("rd_after_wr", fetch(0), 32'hDEAD);
      check_output("rd_after_wr_count", got.size(), 32'd1);
      got.delete();

      // Eviction path
      $display("[TB] eviction");
      wb_base = wb80_count;
      apply_stimulus(1'b1, 32'h100, 32'h1);
      apply_stimulus(1'b1, 32'h102, 32'h2);
      apply_stimulus(1'b0, 32'h100, 32'h0);
      wait_responses(1);
      idle(10);
      check_output("evict_rd", fetch(0), 32'h1);
      check_output("evict_wb_count", wb80_count - wb_base, 32'd1);
      got.delete();

      // Response backpressure: 4 held responses, request FIFO full
      $display("[TB] backpressure");
      rsp_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b0, (i % 2 == 0) ? 32'h100 : 32'h101, 32'h0);
      end
      idle(20);
      @(negedge ACLK);
      check_output("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check_output("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_output("bp_rsp_data",  rsp_data,           32'h1);
      check_output("bp_busy",      {31'd0, busy},      32'd1);
      check_output("bp_none_taken", got.size(),        32'd0);
      @(posedge ACLK);
      #1;
      rsp_ready = 1'b1;
      wait_responses(8);
      idle(10);
      check_output("bp_count", got.size(), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check_output($sformatf("bp_rsp%0d", i), fetch(i), (i % 2 == 0) ? 32'h1 : 32'h6666);
      end
      got.delete();

      // Alternating write/read with random gaps
      $display("[TB] alternating write/read");
      wd_base = wd_count;
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b1, 32'h100, 32'h1000 + i);
         idle($urandom_range(0, 2));
         apply_stimulus(1'b0, 32'h100, 32'h0);
         idle($urandom_range(0, 2));
      end
      wait_responses(10);
      idle(10);
      check_output("alt_count", got.size(), 32'd10);
      for (int i = 0; i < 10; i++) begin
         check_output($sformatf("alt_rd%0d", i), fetch(i), 32'h1000 + i);
      end
      check_output("alt_wr_done", wd_count - wd_base, 32'd10);
      got.delete();

      // Reset with a miss in flight and three requests queued
      $display("[TB] mid-operation reset");
      apply_stimulus(1'b0, 32'h200, 32'h0);
      apply_stimulus(1'b1, 32'h300, 32'h77);
      apply_stimulus(1'b0, 32'h100, 32'h0);
      apply_stimulus(1'b1, 32'h101, 32'h88);
      @(negedge ACLK);
      check_output("pre_rst_busy", {31'd0, busy}, 32'd1);
      rsp_before = got.size();
      wd_before  = wd_count;
      @(posedge ACLK);
      #1;
      ARESETn = 1'b0;
      @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      @(negedge ACLK);
      check_output("post_rst_busy",    {31'd0, busy}, 32'd0);
      check_output("post_rst_address", ADDRESS,       32'd0);
      idle(30);
      check_output("post_rst_no_rsp", got.size(), rsp_before);
      check_output("post_rst_no_wr",  wd_count,   wd_before);
      check_output("post_rst_idle",   {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
